fifo_enq_arbiter: RTL and testbench

FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

---
 rtl/fifo_enq_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_enq_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_arbiter.sv
// Two-requester enqueue arbiter in front of a downstream FIFO enq port.
// Single holding register with bounded-burst alternating grant.
module fifo_enq_arbiter #(
   parameter int WIDTH    = 32,
   parameter int MAXBURST = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             a_enq__ENA,
   input  logic [WIDTH-1:0] a_enq_v,
   output logic             a_enq__RDY,
   input  logic             b_enq__ENA,
   input  logic [WIDTH-1:0] b_enq_v,
   output logic             b_enq__RDY,
   output logic             fifo_enq__ENA,
   output logic [WIDTH-1:0] fifo_enq_v,
   input  logic             fifo_enq__RDY,
   output logic [15:0]      a_count,
   output logic [15:0]      b_count,
   output logic             grant
);

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } grant_e;

   // burst+1 == MAXBURST rewritten as a compare against MAXBURST-1
   localparam logic [3:0] BurstLast = 4'(MAXBURST - 1);

   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic [3:0]       burst_q, burst_d;
   grant_e           grant_q, grant_d;
   logic [15:0]      a_count_q, a_count_d;
   logic [15:0]      b_count_q, b_count_d;

   logic space;
   logic drain;
   logic acc_a;
   logic acc_b;
   logic accept;

   // Holding slot is free, or it empties downstream this cycle
   assign space = !hold_valid_q || fifo_enq__RDY;
   assign drain = hold_valid_q && fifo_enq__RDY;

   assign a_enq__RDY = !RST && space && (grant_q == GNT_A);
   assign b_enq__RDY = !RST && space && (grant_q == GNT_B);

   assign acc_a  = a_enq__ENA && a_enq__RDY;
   assign acc_b  = b_enq__ENA && b_enq__RDY;
   assign accept = acc_a || acc_b;

   assign fifo_enq__ENA = !RST && drain;
   assign fifo_enq_v    = RST ? '0 : hold_data_q;
   assign a_count       = a_count_q;
   assign b_count       = b_count_q;
   assign grant         = (grant_q == GNT_B);

   // Next-state: holding slot, grant/burst pointer and accept counters
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      burst_d      = burst_q;
      grant_d      = grant_q;
      a_count_d    = a_count_q;
      b_count_d    = b_count_q;

      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = acc_b ? b_enq_v : a_enq_v;
      end else if (drain) begin
         hold_valid_d = 1'b0;
      end

      if (space) begin
         if (!accept || (burst_q == BurstLast)) begin
            grant_d = (grant_q == GNT_A) ? GNT_B : GNT_A;
            burst_d = '0;
         end else begin
            burst_d = burst_q + 4'd1;
         end
      end

      if (acc_a) a_count_d = a_count_q + 16'd1;
      if (acc_b) b_count_d = b_count_q + 16'd1;
   end

   // State register with synchronous reset that also discards a held item
   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         burst_q      <= '0;
         grant_q      <= GNT_A;
         a_count_q    <= '0;
         b_count_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         burst_q      <= burst_d;
         grant_q      <= grant_d;
         a_count_q    <= a_count_d;
         b_count_q    <= b_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter (WIDTH=32, MAXBURST=4).
// Expected values are hand-computed per step.
module tb_fifo_enq_arbiter;

   logic        CLK;
   logic        RST;
   logic        a_ena, b_ena;
   logic [31:0] a_v, b_v;
   logic        a_rdy, b_rdy;
   logic        f_ena, f_rdy;
   logic [31:0] f_v;
   logic [15:0] a_cnt, b_cnt;
   logic        gnt;

   int n_chk;
   int n_fail;

   fifo_enq_arbiter #(.WIDTH(32), .MAXBURST(4)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .a_enq__ENA    (a_ena),
      .a_enq_v       (a_v),
      .a_enq__RDY    (a_rdy),
      .b_enq__ENA    (b_ena),
      .b_enq_v       (b_v),
      .b_enq__RDY    (b_rdy),
      .fifo_enq__ENA (f_ena),
      .fifo_enq_v    (f_v),
      .fifo_enq__RDY (f_rdy),
      .a_count       (a_cnt),
      .b_count       (b_cnt),
      .grant         (gnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [31:0] e;
      int          n;
      int          cyc;
      bit          acc;
      n_chk  = 0;
      n_fail = 0;
      RST    = 1'b1;
      a_ena  = 1'b0;
      b_ena  = 1'b0;
      a_v    = '0;
      b_v    = '0;
      f_rdy  = 1'b1;
      tick();
      tick();
      chk("rst_a_rdy", 32'(a_rdy), 0);
      chk("rst_b_rdy", 32'(b_rdy), 0);
      chk("rst_f_ena", 32'(f_ena), 0);
      chk("rst_f_v", f_v, 0);
      chk("rst_a_cnt", 32'(a_cnt), 0);
      chk("rst_b_cnt", 32'(b_cnt), 0);
      chk("rst_gnt", 32'(gnt), 0);
      RST = 1'b0;
      #1;
      chk("post_rst_a_rdy", 32'(a_rdy), 1);
      chk("post_rst_b_rdy", 32'(b_rdy), 0);

      // Single requester A, three back-to-back items
      a_ena = 1'b1;
      a_v   = 32'h11;
      tick();
      chk("s1_ena", 32'(f_ena), 1);
      chk("s1_v", f_v, 32'h11);
      a_v = 32'h22;
      tick();
      chk("s2_ena", 32'(f_ena), 1);
      chk("s2_v", f_v, 32'h22);
      a_v = 32'h33;
      tick();
      chk("s3_ena", 32'(f_ena), 1);
      chk("s3_v", f_v, 32'h33);
      a_ena = 1'b0;
      tick();
      chk("s4_ena", 32'(f_ena), 0);
      chk("s4_a_cnt", 32'(a_cnt), 3);
      chk("s4_gnt", 32'(gnt), 1);
      tick();
      chk("s5_gnt", 32'(gnt), 0);

      // Both saturating: AAAABBBBAAAABBBB
      for (int i = 0; i < 16; i++) begin
         a_ena = a_rdy;
         b_ena = b_rdy;
         a_v   = 32'hA00 + 32'(i);
         b_v   = 32'hB00 + 32'(i);
         e     = (((i / 4) % 2) == 1) ? 32'hB00 + 32'(i)
                                      : 32'hA00 + 32'(i);
         tick();
         chk($sformatf("sat_v%0d", i), f_v, e);
      end
      a_ena = 1'b0;
      b_ena = 1'b0;
      chk("sat_a_cnt", 32'(a_cnt), 11);
      chk("sat_b_cnt", 32'(b_cnt), 8);
      chk("sat_gnt", 32'(gnt), 0);
      tick();
      chk("sat_idle_gnt", 32'(gnt), 1);
      chk("sat_idle_ena", 32'(f_ena), 0);

      // Backpressure with B holding an item
      b_ena = 1'b1;
      b_v   = 32'hC1;
      tick();
      chk("bp_load_v", f_v, 32'hC1);
      f_rdy = 1'b0;
      b_ena = 1'b0;
      #1;
      chk("bp_a_rdy", 32'(a_rdy), 0);
      chk("bp_b_rdy", 32'(b_rdy), 0);
      chk("bp_f_ena", 32'(f_ena), 0);
      b_ena = 1'b1;
      b_v   = 32'hDEAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_v%0d", i), f_v, 32'hC1);
         chk($sformatf("bp_rdy%0d", i), 32'(b_rdy), 0);
         chk($sformatf("bp_gnt%0d", i), 32'(gnt), 1);
      end
      chk("bp_b_cnt", 32'(b_cnt), 9);
      b_ena = 1'b0;
      f_rdy = 1'b1;
      #1;
      chk("bp_rel_rdy", 32'(b_rdy), 1);
      chk("bp_rel_ena", 32'(f_ena), 1);
      b_ena = 1'b1;
      b_v   = 32'hC2;
      tick();
      chk("bp_c2_v", f_v, 32'hC2);
      chk("bp_c2_ena", 32'(f_ena), 1);
      chk("bp_c2_gnt", 32'(gnt), 1);
      b_v = 32'hC3;
      tick();
      chk("bp_c3_gnt", 32'(gnt), 1);
      b_v = 32'hC4;
      tick();
      chk("bp_c4_v", f_v, 32'hC4);
      chk("bp_c4_gnt", 32'(gnt), 0);
      chk("bp_b_cnt2", 32'(b_cnt), 12);
      b_ena = 1'b0;

      // Idle skip: grant on B, B idle, A waiting
      tick();
      chk("skip_gnt1", 32'(gnt), 1);
      a_ena = 1'b1;
      a_v   = 32'hE0;
      #1;
      chk("skip_a_rdy0", 32'(a_rdy), 0);
      tick();
      chk("skip_gnt0", 32'(gnt), 0);
      chk("skip_a_cnt0", 32'(a_cnt), 11);
      chk("skip_a_rdy1", 32'(a_rdy), 1);
      a_v = 32'hE1;
      tick();
      chk("skip_v", f_v, 32'hE1);
      chk("skip_a_cnt1", 32'(a_cnt), 12);
      a_v = 32'hE2;
      tick();
      chk("pre_rst_v", f_v, 32'hE2);

      // Reset with an item held and burst at 2
      a_ena = 1'b0;
      RST   = 1'b1;
      #1;
      chk("mrst_f_ena_c", 32'(f_ena), 0);
      chk("mrst_f_v_c", f_v, 0);
      chk("mrst_a_rdy_c", 32'(a_rdy), 0);
      tick();
      chk("mrst_a_cnt", 32'(a_cnt), 0);
      chk("mrst_b_cnt", 32'(b_cnt), 0);
      chk("mrst_f_ena", 32'(f_ena), 0);
      chk("mrst_gnt", 32'(gnt), 0);
      RST = 1'b0;
      #1;
      chk("mrst_rel_a_rdy", 32'(a_rdy), 1);
      chk("mrst_rel_b_rdy", 32'(b_rdy), 0);
      chk("mrst_rel_f_ena", 32'(f_ena), 0);
      chk("mrst_rel_f_v", f_v, 0);

      // Counter wrap on A
      n   = 0;
      cyc = 0;
      a_v = 32'h5A;
      while (n < 65535 && cyc < 90000) begin
         acc   = a_rdy;
         a_ena = acc;
         tick();
         if (acc) n++;
         cyc++;
      end
      a_ena = 1'b0;
      chk("wrap_accepts", 32'(n), 65535);
      chk("wrap_a_ffff", 32'(a_cnt), 32'hFFFF);
      cyc = 0;
      while (!a_rdy && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("wrap_rdy_wait", 32'(a_rdy), 1);
      a_ena = 1'b1;
      tick();
      a_ena = 1'b0;
      chk("wrap_a_zero", 32'(a_cnt), 0);
      chk("wrap_b_cnt", 32'(b_cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
